calc_stream_engine: RTL and testbench

//  Parametrised streaming calculator core, successor to the fixed 64-bit/adder32 datapath.
//  - Reads operand-pair words from an external sync-read SRAM port; computes add or sub per word.
//  - Packs two results per memory word and writes them back through a separate write port.
//  - Integrates sequencing, ALU and result packing; sits between cfg registers and the SRAM banks.

---
 rtl/calc_stream_engine_if.sv | 25 ++
 rtl/calc_stream_engine.sv | 184 ++++++++++++++++++
 tb/tb_calc_stream_engine.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_stream_engine_if.sv
// calc_stream_engine_if
//   SRAM-side bus of the streaming calculator: one sync-read port and one
//   masked write port, both word addressed.
//   Parameters: ADDR_W (word-address width), WORD_W (word width, multiple of 16).
//   Signals:
//     read    read enable                 r_addr  read word address
//     r_data  read data, {b,a}
//     write   write enable                w_addr  write word address
//     w_data  packed results {hi,lo}      w_mask  byte write mask
//   Modports: master = engine side, slave = SRAM side.
interface calc_stream_engine_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 64
);
  logic              read;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;
  logic              write;
  logic [ADDR_W-1:0] w_addr;
  logic [WORD_W-1:0] w_data;
  logic [WORD_W/8-1:0] w_mask;

  modport master (output read, r_addr, write, w_addr, w_data, w_mask, input r_data);
  modport slave  (input read, r_addr, write, w_addr, w_data, w_mask, output r_data);
endinterface

// File: rtl/calc_stream_engine.sv
// calc_stream_engine
//   Streaming add/sub core. Reads N operand-pair words {b,a} from a sync-read
//   SRAM, computes a+b or a-b per word and packs two results per written word.
//   Optional feature macro: CALC_SAT_EN (saturating ALU; default wraps).
//   Parameters: ADDR_W, WORD_W (operand width WORD_W/2), RD_LAT (1..3).
//   Ports:
//     clk_i, rst_ni               clock, asynchronous active-low reset
//     start_i, mode_i             start pulse (IDLE only), 0 add / 1 sub
//     read_start/end_addr_i       inclusive read range, wraps through 0
//     write_start/end_addr_i      circular write window
//     busy_o, done_o, ovf_o       status: busy, one-cycle done, sticky overflow
//     mem                         SRAM bus (calc_stream_engine_if.master)
module calc_stream_engine #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] read_start_addr_i,
  input  logic [ADDR_W-1:0] read_end_addr_i,
  input  logic [ADDR_W-1:0] write_start_addr_i,
  input  logic [ADDR_W-1:0] write_end_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  calc_stream_engine_if.master mem
);
  localparam int OP_W   = WORD_W / 2;
  localparam int MASK_W = WORD_W / 8;
  localparam logic [MASK_W-1:0] MASK_FULL = '1;
  localparam logic [MASK_W-1:0] MASK_LO   = {{(MASK_W/2){1'b0}}, {(MASK_W/2){1'b1}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state;
  logic                busy_q, done_q, ovf_q, read_q, write_q;
  logic [ADDR_W-1:0]   r_addr_q, w_addr_q;
  logic [WORD_W-1:0]   w_data_q;
  logic [MASK_W-1:0]   w_mask_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   rd_end_q, wr_start_q, wr_end_q, wr_next_q;
  logic [OP_W-1:0]     lo_hold;
  logic                phase_q;
  logic                final_wr_q;
  logic [RD_LAT-1:0]   vld_sr, last_sr;

  logic [OP_W-1:0]     op_a, op_b, res;
  logic [OP_W:0]       sum_ext, diff_ext;
  logic                flow;
  logic                ret_vld, ret_last;
  logic [ADDR_W-1:0]   next_wr;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ovf_o       = ovf_q;
  assign mem.read    = read_q;
  assign mem.r_addr  = r_addr_q;
  assign mem.write   = write_q;
  assign mem.w_addr  = w_addr_q;
  assign mem.w_data  = w_data_q;
  assign mem.w_mask  = w_mask_q;

  // Oldest stage of the tracking shift registers lines up with SRAM data.
  assign ret_vld  = vld_sr[RD_LAT-1];
  assign ret_last = last_sr[RD_LAT-1];

  // Circular write window: after write_end the next write returns to write_start.
  assign next_wr = (wr_next_q == wr_end_q) ? wr_start_q : wr_next_q + ADDR_W'(1);

  // ALU on the returned word; the extra top bit is carry (add) or borrow (sub).
  always_comb begin
    op_a     = mem.r_data[OP_W-1:0];
    op_b     = mem.r_data[WORD_W-1:OP_W];
    sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    diff_ext = {1'b0, op_a} - {1'b0, op_b};
    flow     = mode_q ? diff_ext[OP_W] : sum_ext[OP_W];
    res      = mode_q ? diff_ext[OP_W-1:0] : sum_ext[OP_W-1:0];
`ifdef CALC_SAT_EN
    if (flow) res = mode_q ? '0 : '1;
`endif
  end

  // Sequencer, read-tracking pipeline and result packer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      r_addr_q   <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_mask_q   <= '0;
      mode_q     <= 1'b0;
      rd_end_q   <= '0;
      wr_start_q <= '0;
      wr_end_q   <= '0;
      wr_next_q  <= '0;
      lo_hold    <= '0;
      phase_q    <= 1'b0;
      final_wr_q <= 1'b0;
      vld_sr     <= '0;
      last_sr    <= '0;
    end else begin
      done_q  <= 1'b0;
      write_q <= 1'b0;

      // Each issued read enters the tracker; the last one is tagged.
      vld_sr[0]  <= read_q;
      last_sr[0] <= read_q && (r_addr_q == rd_end_q);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= READ;
            busy_q     <= 1'b1;
            ovf_q      <= 1'b0;
            mode_q     <= mode_i;
            read_q     <= 1'b1;
            r_addr_q   <= read_start_addr_i;
            rd_end_q   <= read_end_addr_i;
            wr_start_q <= write_start_addr_i;
            wr_end_q   <= write_end_addr_i;
            wr_next_q  <= write_start_addr_i;
            phase_q    <= 1'b0;
            final_wr_q <= 1'b0;
          end
        end
        READ: begin
          if (r_addr_q == rd_end_q) begin
            read_q <= 1'b0;
            state  <= DRAIN;
          end else begin
            r_addr_q <= r_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (write_q && final_wr_q) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Even results wait in the low half; an odd result (or a lone final
      // even result) issues a write on the next cycle.
      if (ret_vld) begin
        if (flow) ovf_q <= 1'b1;
        if (!phase_q) begin
          lo_hold <= res;
          phase_q <= 1'b1;
          if (ret_last) begin
            write_q    <= 1'b1;
            w_data_q   <= {{OP_W{1'b0}}, res};
            w_mask_q   <= MASK_LO;
            w_addr_q   <= wr_next_q;
            wr_next_q  <= next_wr;
            final_wr_q <= 1'b1;
          end
        end else begin
          phase_q    <= 1'b0;
          write_q    <= 1'b1;
          w_data_q   <= {res, lo_hold};
          w_mask_q   <= MASK_FULL;
          w_addr_q   <= wr_next_q;
          wr_next_q  <= next_wr;
          final_wr_q <= ret_last;
        end
      end
    end
  end
endmodule

// File: tb/tb_calc_stream_engine.sv
// tb_calc_stream_engine
//   Directed bench for calc_stream_engine: one instance with RD_LAT=1 and one
//   with RD_LAT=3, each behind a small sync-read SRAM model. Reads and writes
//   are logged on the falling edge and compared against hand-computed values.
module tb_calc_stream_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0, mode = 1'b0;
  logic [9:0] rsa = '0, rea = '0, wsa = '0, wea = '0;
  logic       busy1, done1, ovf1, busy3, done3, ovf3;

  logic [63:0] mem [0:1023];
  logic [63:0] pipe1 = '0;
  logic [63:0] pipe3 [3];

  int cyc = 0, n_checks = 0, n_errors = 0, done_cnt1 = 0, done_cnt3 = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [63:0] data;
    logic [7:0]  mask;
    int          cyc;
  } xact_t;

  xact_t rlog1[$], wlog1[$], rlog3[$], wlog3[$];

  calc_stream_engine_if #(.ADDR_W(10), .WORD_W(64)) bus1 ();
  calc_stream_engine_if #(.ADDR_W(10), .WORD_W(64)) bus3 ();

  calc_stream_engine #(.ADDR_W(10), .WORD_W(64), .RD_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .mode_i(mode),
    .read_start_addr_i(rsa), .read_end_addr_i(rea),
    .write_start_addr_i(wsa), .write_end_addr_i(wea),
    .busy_o(busy1), .done_o(done1), .ovf_o(ovf1), .mem(bus1)
  );

  calc_stream_engine #(.ADDR_W(10), .WORD_W(64), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .mode_i(mode),
    .read_start_addr_i(rsa), .read_end_addr_i(rea),
    .write_start_addr_i(wsa), .write_end_addr_i(wea),
    .busy_o(busy3), .done_o(done3), .ovf_o(ovf3), .mem(bus3)
  );

  always #5 clk = ~clk;

  // SRAM models with 1- and 3-cycle read latency plus a cycle counter.
  always @(posedge clk) begin
    cyc++;
    if (bus1.read) pipe1 <= mem[bus1.r_addr];
    pipe3[0] <= bus3.read ? mem[bus3.r_addr] : 64'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign bus1.r_data = pipe1;
  assign bus3.r_data = pipe3[2];

  // Falling-edge monitor: log every read, write and done pulse.
  always @(negedge clk) begin
    xact_t t;
    if (bus1.read) begin t.addr = bus1.r_addr; t.data = '0; t.mask = '0; t.cyc = cyc; rlog1.push_back(t); end
    if (bus1.write) begin t.addr = bus1.w_addr; t.data = bus1.w_data; t.mask = bus1.w_mask; t.cyc = cyc; wlog1.push_back(t); end
    if (bus3.read) begin t.addr = bus3.r_addr; t.data = '0; t.mask = '0; t.cyc = cyc; rlog3.push_back(t); end
    if (bus3.write) begin t.addr = bus3.w_addr; t.data = bus3.w_data; t.mask = bus3.w_mask; t.cyc = cyc; wlog3.push_back(t); end
    if (done1) done_cnt1++;
    if (done3) done_cnt3++;
  end

  task automatic start_run(input int sel, input logic m, input logic [9:0] rs, re, ws, we);
    @(negedge clk);
    if (sel == 1) begin rlog1.delete(); wlog1.delete(); done_cnt1 = 0; end
    else begin rlog3.delete(); wlog3.delete(); done_cnt3 = 0; end
    mode = m; rsa = rs; rea = re; wsa = ws; wea = we;
    if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n = 0;
    while (((sel == 1) ? done_cnt1 : done_cnt3) == 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (((sel == 1) ? done_cnt1 : done_cnt3) == 0) begin
      n_errors++;
      $display("[TB] FAIL done_timeout dut%0d: no done_o within %0d cycles", sel, n);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy1, done1, ovf1, bus1.read, bus1.write, bus1.r_addr, bus1.w_addr, bus1.w_data, bus1.w_mask} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_state dut1: got busy=%b rd=%b wr=%b raddr=%h waddr=%h wdata=%h mask=%h, required all 0",
               busy1, bus1.read, bus1.write, bus1.r_addr, bus1.w_addr, bus1.w_data, bus1.w_mask);
    end
    n_checks++;
    if ({busy3, done3, ovf3, bus3.read, bus3.write, bus3.r_addr, bus3.w_addr, bus3.w_data, bus3.w_mask} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_state dut3: outputs not all 0 (busy=%b rd=%b wr=%b)", busy3, bus3.read, bus3.write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_run(1, 1'b0, 10'h200, 10'h20F, 10'h300, 10'h3FF);
    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (bus1.read !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL midrun_reading: read_o=%b, required 1", bus1.read);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy1, done1, ovf1, bus1.read, bus1.write, bus1.r_addr, bus1.w_addr, bus1.w_data, bus1.w_mask} !== '0) begin
      n_errors++;
      $display("[TB] FAIL midrun_abort: busy=%b rd=%b wr=%b raddr=%h waddr=%h wdata=%h, required all 0",
               busy1, bus1.read, bus1.write, bus1.r_addr, bus1.w_addr, bus1.w_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rlog1.delete(); wlog1.delete(); done_cnt1 = 0;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (wlog1.size() != 0 || rlog1.size() != 0 || busy1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL post_reset_quiet: writes=%0d reads=%0d busy=%b, required 0 0 0", wlog1.size(), rlog1.size(), busy1);
    end
  endtask

  task automatic test_add();
    logic [63:0] exp_d [2];
    exp_d = '{64'h00000007_00000003, 64'h0000000F_0000000B};
    mem[10'h010] = {32'd2, 32'd1};
    mem[10'h011] = {32'd4, 32'd3};
    mem[10'h012] = {32'd6, 32'd5};
    mem[10'h013] = {32'd8, 32'd7};
    start_run(1, 1'b0, 10'h010, 10'h013, 10'h040, 10'h04F);
    wait_done(1);
    n_checks++;
    if (rlog1.size() != 4 || wlog1.size() != 2) begin
      n_errors++;
      $display("[TB] FAIL add_counts: reads=%0d writes=%0d, required 4 2", rlog1.size(), wlog1.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= wlog1.size() || wlog1[i].data !== exp_d[i] || wlog1[i].mask !== 8'hFF || wlog1[i].addr !== 10'h040 + 10'(i)) begin
        n_errors++;
        $display("[TB] FAIL add_write%0d: got addr=%h data=%h mask=%h, required addr=%h data=%h mask=ff",
                 i, wlog1[i].addr, wlog1[i].data, wlog1[i].mask, 10'h040 + 10'(i), exp_d[i]);
      end
    end
    n_checks++;
    if (rlog1.size() > 0 && wlog1.size() > 0 && wlog1[0].cyc - rlog1[0].cyc != 3) begin
      n_errors++;
      $display("[TB] FAIL add_latency: first write %0d cycles after first read, required 3", wlog1[0].cyc - rlog1[0].cyc);
    end
    n_checks++;
    if (done_cnt1 != 1 || ovf1 !== 1'b0 || busy1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL add_status: done pulses=%0d ovf=%b busy=%b, required 1 0 0", done_cnt1, ovf1, busy1);
    end
  endtask

  task automatic test_odd_sub();
    mem[10'h020] = {32'd1, 32'd5};
    mem[10'h021] = {32'd2, 32'd9};
    mem[10'h022] = {32'd3, 32'd3};
    start_run(1, 1'b1, 10'h020, 10'h022, 10'h100, 10'h1FF);
    wait_done(1);
    n_checks++;
    if (wlog1.size() != 2) begin
      n_errors++;
      $display("[TB] FAIL odd_count: writes=%0d, required 2", wlog1.size());
    end
    n_checks++;
    if (wlog1.size() < 1 || wlog1[0].addr !== 10'h100 || wlog1[0].data !== {32'd7, 32'd4} || wlog1[0].mask !== 8'hFF) begin
      n_errors++;
      $display("[TB] FAIL odd_write0: got addr=%h data=%h mask=%h, required 100 00000007_00000004 ff",
               wlog1[0].addr, wlog1[0].data, wlog1[0].mask);
    end
    n_checks++;
    if (wlog1.size() < 2 || wlog1[1].addr !== 10'h101 || wlog1[1].data !== 64'h0 || wlog1[1].mask !== 8'h0F) begin
      n_errors++;
      $display("[TB] FAIL odd_write1: got addr=%h data=%h mask=%h, required 101 0 0f",
               wlog1[1].addr, wlog1[1].data, wlog1[1].mask);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_ra [4];
    exp_ra = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    mem[10'h3FE] = {32'd0, 32'd1};
    mem[10'h3FF] = {32'd0, 32'd2};
    mem[10'h000] = {32'd0, 32'd3};
    mem[10'h001] = {32'd0, 32'd4};
    start_run(1, 1'b0, 10'h3FE, 10'h001, 10'h020, 10'h020);
    wait_done(1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= rlog1.size() || rlog1[i].addr !== exp_ra[i] || rlog1[i].cyc != rlog1[0].cyc + i) begin
        n_errors++;
        $display("[TB] FAIL wrap_read%0d: got addr=%h, required %h on consecutive cycles", i, rlog1[i].addr, exp_ra[i]);
      end
    end
    n_checks++;
    if (wlog1.size() != 2 || wlog1[0].addr !== 10'h020 || wlog1[1].addr !== 10'h020) begin
      n_errors++;
      $display("[TB] FAIL wrap_write_addr: writes=%0d addr0=%h addr1=%h, required 2 020 020",
               wlog1.size(), wlog1[0].addr, wlog1[1].addr);
    end
    n_checks++;
    if (wlog1.size() < 2 || wlog1[0].data !== {32'd2, 32'd1} || wlog1[1].data !== {32'd4, 32'd3}) begin
      n_errors++;
      $display("[TB] FAIL wrap_write_data: got %h %h, required 00000002_00000001 00000004_00000003",
               wlog1[0].data, wlog1[1].data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_add, exp_sub;
`ifdef CALC_SAT_EN
    exp_add = 32'hFFFFFFFF;
    exp_sub = 32'h0;
`else
    exp_add = 32'h0;
    exp_sub = 32'hFFFFFFFF;
`endif
    mem[10'h030] = {32'd1, 32'hFFFFFFFF};
    mem[10'h031] = {32'd1, 32'd0};
    mem[10'h032] = {32'd2, 32'd1};

    start_run(1, 1'b0, 10'h030, 10'h030, 10'h080, 10'h080);
    wait_done(1);
    n_checks++;
    if (wlog1.size() != 1 || wlog1[0].data !== {32'h0, exp_add} || wlog1[0].mask !== 8'h0F || ovf1 !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ovf_add: writes=%0d data=%h mask=%h ovf=%b, required 1 %h 0f 1",
               wlog1.size(), wlog1[0].data, wlog1[0].mask, ovf1, {32'h0, exp_add});
    end

    start_run(1, 1'b1, 10'h031, 10'h031, 10'h080, 10'h080);
    wait_done(1);
    n_checks++;
    if (wlog1.size() != 1 || wlog1[0].data !== {32'h0, exp_sub} || ovf1 !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ovf_sub: writes=%0d data=%h ovf=%b, required 1 %h 1",
               wlog1.size(), wlog1[0].data, ovf1, {32'h0, exp_sub});
    end

    start_run(1, 1'b0, 10'h032, 10'h032, 10'h080, 10'h080);
    n_checks++;
    if (ovf1 !== 1'b0 || busy1 !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ovf_clear_at_start: ovf=%b busy=%b, required 0 1", ovf1, busy1);
    end
    wait_done(1);
    n_checks++;
    if (wlog1.size() != 1 || wlog1[0].data !== 64'h3 || ovf1 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL ovf_clean_run: writes=%0d data=%h ovf=%b, required 1 3 0", wlog1.size(), wlog1[0].data, ovf1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d [3];
    exp_d = '{{32'd12, 32'd10}, {32'd16, 32'd14}, {32'd20, 32'd18}};
    for (int i = 0; i < 6; i++) mem[10'h050 + 10'(i)] = {32'(i + 10), 32'(i)};
    start_run(3, 1'b0, 10'h050, 10'h055, 10'h060, 10'h06F);
    @(negedge clk);
    mode = 1'b1; rsa = 10'h000; rea = 10'h3FF; wsa = 10'h200; wea = 10'h200;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_done(3);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (rlog3.size() != 6 || wlog3.size() != 3 || done_cnt3 != 1) begin
      n_errors++;
      $display("[TB] FAIL lat3_counts: reads=%0d writes=%0d done=%0d, required 6 3 1", rlog3.size(), wlog3.size(), done_cnt3);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= rlog3.size() || rlog3[i].addr !== 10'h050 + 10'(i) || rlog3[i].cyc != rlog3[0].cyc + i) begin
        n_errors++;
        $display("[TB] FAIL lat3_read%0d: got addr=%h, required %h back-to-back", i, rlog3[i].addr, 10'h050 + 10'(i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= wlog3.size() || wlog3[i].data !== exp_d[i] || wlog3[i].addr !== 10'h060 + 10'(i)) begin
        n_errors++;
        $display("[TB] FAIL lat3_write%0d: got addr=%h data=%h, required %h %h",
                 i, wlog3[i].addr, wlog3[i].data, 10'h060 + 10'(i), exp_d[i]);
      end
    end
    n_checks++;
    if (rlog3.size() > 0 && wlog3.size() > 0 && wlog3[0].cyc - rlog3[0].cyc != 5) begin
      n_errors++;
      $display("[TB] FAIL lat3_latency: first write %0d cycles after first read, required 5", wlog3[0].cyc - rlog3[0].cyc);
    end
  endtask

  // Sequence of directed scenarios followed by the summary.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    pipe3[0] = '0; pipe3[1] = '0; pipe3[2] = '0;
    test_reset();
    test_add();
    test_odd_sub();
    test_wrap();
    test_overflow();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit in case a scenario stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
